// File: rtl/approx_error_accumulator_pkg.sv
// Shared types and constants for the approximate-multiplier error accumulator.
package approx_error_accumulator_pkg;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 17;
    localparam int SUM_W  = 33;

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [SUM_W-1:0]  sum_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/approx_error_accumulator_err_distance_stage.sv
// Stage 1: signed difference, absolute error distance and mismatch flag,
// registered on the input handshake.
module err_distance_stage #(
    parameter int PROD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs,
    input  logic [PROD_W-1:0] exact_p,
    input  logic [PROD_W-1:0] approx_p,
    output logic              v1,
    output logic [PROD_W:0]   diff,
    output logic [PROD_W-1:0] ed,
    output logic              ne
);
    logic              v1_q, v1_d;
    logic [PROD_W:0]   diff_q, diff_d, diff_c, neg_c;
    logic [PROD_W-1:0] ed_q, ed_d, ed_c;
    logic              ne_q, ne_d;

    always_comb begin
        diff_c = {1'b0, approx_p} - {1'b0, exact_p};
        neg_c  = -diff_c;
        // |diff| always fits PROD_W bits since both operands are unsigned PROD_W
        ed_c   = diff_c[PROD_W] ? neg_c[PROD_W-1:0] : diff_c[PROD_W-1:0];
        v1_d   = hs;
        diff_d = diff_q;
        ed_d   = ed_q;
        ne_d   = ne_q;
        if (hs) begin
            diff_d = diff_c;
            ed_d   = ed_c;
            ne_d   = (diff_c != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            diff_q <= '0;
            ed_q   <= '0;
            ne_q   <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            diff_q <= diff_d;
            ed_q   <= ed_d;
            ne_q   <= ne_d;
        end
    end

    assign v1   = v1_q;
    assign diff = diff_q;
    assign ed   = ed_q;
    assign ne   = ne_q;
endmodule

// File: rtl/approx_error_accumulator.sv
// Error-metric accumulator: counts mismatches, sums |error| and signed error,
// and tracks the maximum error distance over a programmed number of samples.
module approx_error_accumulator
    import approx_error_accumulator_pkg::*;
#(
    parameter int PROD_W = approx_error_accumulator_pkg::PROD_W,
    parameter int CNT_W  = approx_error_accumulator_pkg::CNT_W,
    parameter int SUM_W  = approx_error_accumulator_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] exact_p,
    input  logic [PROD_W-1:0] approx_p,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_ed,
    output logic [PROD_W-1:0] max_ed,
    output logic [SUM_W:0]    sum_err
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d, acc_q, acc_d, acc_inc;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [SUM_W-1:0]  sum_ed_q, sum_ed_d;
    logic [PROD_W-1:0] max_ed_q, max_ed_d;
    logic [SUM_W:0]    sum_err_q, sum_err_d;
    logic              hs, v1, ne;
    logic [PROD_W:0]   diff;
    logic [PROD_W-1:0] ed;

    assign in_ready = (state_q == RUN);
    assign hs       = in_valid & in_ready;

    err_distance_stage #(.PROD_W(PROD_W)) u_stage1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .hs       (hs),
        .exact_p  (exact_p),
        .approx_p (approx_p),
        .v1       (v1),
        .diff     (diff),
        .ed       (ed),
        .ne       (ne)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        acc_d       = acc_q;
        acc_inc     = acc_q + 1'b1;
        err_count_d = err_count_q;
        sum_ed_d    = sum_ed_q;
        max_ed_d    = max_ed_q;
        sum_err_d   = sum_err_q;

        if (v1) begin
            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, ne};
            sum_ed_d    = sum_ed_q + {{(SUM_W-PROD_W){1'b0}}, ed};
            sum_err_d   = sum_err_q + {{(SUM_W-PROD_W){diff[PROD_W]}}, diff};
            if (ed > max_ed_q) max_ed_d = ed;
        end

        // v1 is never set in IDLE/DONE, so the clear below cannot lose a sample
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d         = num_samples;
                    acc_d       = '0;
                    err_count_d = '0;
                    sum_ed_d    = '0;
                    max_ed_d    = '0;
                    sum_err_d   = '0;
                    state_d     = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    acc_d = acc_inc;
                    if (acc_inc == n_q) state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            acc_q       <= '0;
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            sum_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            err_count_q <= err_count_d;
            sum_ed_q    <= sum_ed_d;
            max_ed_q    <= max_ed_d;
            sum_err_q   <= sum_err_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign err_count = err_count_q;
    assign sum_ed    = sum_ed_q;
    assign max_ed    = max_ed_q;
    assign sum_err   = sum_err_q;
endmodule

// File: tb/tb_approx_error_accumulator.sv
// Directed bench for approx_error_accumulator with a per-run expected-result queue.
module tb_approx_error_accumulator;
    import approx_error_accumulator_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    cnt_t             num_samples = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    prod_t            exact_p = '0;
    prod_t            approx_p = '0;
    logic             busy, done;
    cnt_t             err_count;
    sum_t             sum_ed;
    prod_t            max_ed;
    logic [SUM_W:0]   sum_err;

    typedef struct {
        cnt_t           err;
        sum_t           sed;
        prod_t          med;
        logic [SUM_W:0] serr;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     passed = 0;
    longint m_err, m_sed, m_med, m_serr;

    always #5 clk = ~clk;

    approx_error_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .exact_p(exact_p), .approx_p(approx_p),
        .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed),
        .max_ed(max_ed), .sum_err(sum_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // 2x2 block with 3*3=7, composed recursively into 4x4 and 8x8
    function automatic int am2(input int a, input int b);
        return (a == 3 && b == 3) ? 7 : a * b;
    endfunction
    function automatic int am4(input int a, input int b);
        return (am2(a >> 2, b >> 2) << 4) + ((am2(a >> 2, b & 3) + am2(a & 3, b >> 2)) << 2)
               + am2(a & 3, b & 3);
    endfunction
    function automatic int am8(input int a, input int b);
        return (am4(a >> 4, b >> 4) << 8) + ((am4(a >> 4, b & 15) + am4(a & 15, b >> 4)) << 4)
               + am4(a & 15, b & 15);
    endfunction

    // Called at posedge+1; returns at posedge+1
    task automatic do_start(input int n);
        start = 1'b1;
        num_samples = cnt_t'(n);
        m_err = 0; m_sed = 0; m_med = 0; m_serr = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int e, input int a);
        bit     got = 0;
        longint d;
        exact_p = prod_t'(e);
        approx_p = prod_t'(a);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                @(posedge clk); #1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!got) chk("handshake_timeout", 64'd0, 64'd1);
        else begin
            d = longint'(a) - longint'(e);
            if (d != 0) m_err++;
            m_sed += (d < 0) ? -d : d;
            if (((d < 0) ? -d : d) > m_med) m_med = (d < 0) ? -d : d;
            m_serr += d;
        end
    endtask

    task automatic push_expected();
        exp_t x;
        x.err = cnt_t'(m_err);
        x.sed = sum_t'(m_sed);
        x.med = prod_t'(m_med);
        x.serr = (SUM_W+1)'(m_serr);
        sb.push_back(x);
    endtask

    task automatic wait_done(input string tag);
        bit   seen = 0;
        exp_t x;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        if (!seen) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        else if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        else begin
            x = sb.pop_front();
            chk({tag, "_err_count"}, 64'(err_count), 64'(x.err));
            chk({tag, "_sum_ed"},    64'(sum_ed),    64'(x.sed));
            chk({tag, "_max_ed"},    64'(max_ed),    64'(x.med));
            chk({tag, "_sum_err"},   64'(sum_err),   64'(x.serr));
            chk({tag, "_busy"},      64'(busy),      64'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic single_sample(input string tag);
        do_start(1);
        send(9, 7);
        @(negedge clk);
        chk({tag, "_ready_drop"}, 64'(in_ready), 64'd0);
        chk({tag, "_done_early"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, "_done_t2"}, 64'(done), 64'd1);
        push_expected();
        wait_done(tag);
    endtask

    initial begin
        #2;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_results", 64'(err_count) | 64'(sum_ed) | 64'(max_ed) | 64'(sum_err), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        single_sample("single");

        // Mixed pairs with a gap between pairs 2 and 3
        do_start(4);
        send(9, 7);
        send(225, 225);
        repeat (3) @(posedge clk);
        #1;
        send(100, 104);
        send(0, 0);
        push_expected();
        wait_done("mixed");

        // Restart with extreme operands and an ignored mid-run start
        do_start(2);
        @(negedge clk);
        chk("restart_clear", 64'(err_count) | 64'(sum_ed) | 64'(max_ed) | 64'(sum_err), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        send(0, 'hFFFF);
        start = 1'b1;
        num_samples = cnt_t'(5);
        @(posedge clk); #1;
        start = 1'b0;
        send('hFFFF, 0);
        push_expected();
        wait_done("restart");

        // Zero-sample run
        do_start(0);
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        push_expected();
        wait_done("zero");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_no_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset after 1 of 3 samples
        do_start(3);
        send(5, 6);
        @(posedge clk); #1;
        chk("midrun_partial", 64'(sum_ed), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_ready", 64'(in_ready), 64'd0);
        chk("midrun_rst_done", 64'(done), 64'd0);
        chk("midrun_rst_results", 64'(err_count) | 64'(sum_ed) | 64'(max_ed) | 64'(sum_err), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        single_sample("post_reset");

        // Full 8x8 operand space
        do_start(65536);
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                send(a * b, am8(a, b));
        push_expected();
        wait_done("sweep");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
